mure_uop_fifo: RTL

- Buffers retired-instruction uops between the CVA6 commit interface and the trace encoder.
- Upstream itype detection delivers up to NRET fifo_entry_s records per cycle.
- This block compacts the valid lanes in program order, stores them, and presents one record per cycle on a valid/ready port to the encoder.
- The commit side cannot stall. Lack of space is reported as a sticky overflow.

---
 rtl/mure_pkg.sv | 38 +++
 rtl/mure_uop_fifo_if.sv | 35 +++
 rtl/mure_uop_fifo.sv | 98 +++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// mure_pkg: shared types and constants for the MURE trace front-end.
//   NRET            commit lanes delivered per cycle
//   UOP_FIFO_DEPTH  default depth of the uop FIFO
//   itype_e         instruction type from the upstream itype detector
//   fifo_entry_s    one retired-uop record
//   popcount_nret   number of set lanes in a NRET-wide valid vector
package mure_pkg;

    localparam int unsigned NRET           = 2;
    localparam int unsigned XLEN           = 64;
    localparam int unsigned UOP_FIFO_DEPTH = 16;
    localparam int unsigned NPUSH_W        = $clog2(NRET + 1);

    typedef enum logic [2:0] {
        ITYPE_STD  = 3'd0,
        ITYPE_EXC  = 3'd1,
        ITYPE_INT  = 3'd2,
        ITYPE_ERET = 3'd3,
        ITYPE_NTB  = 3'd4,
        ITYPE_TB   = 3'd5,
        ITYPE_UIJ  = 3'd6,
        ITYPE_UJ   = 3'd7
    } itype_e;

    typedef struct packed {
        logic            valid;
        itype_e          itype;
        logic [XLEN-1:0] pc;
    } fifo_entry_s;

    function automatic logic [NPUSH_W-1:0] popcount_nret(input logic [NRET-1:0] v);
        logic [NPUSH_W-1:0] n;
        n = '0;
        for (int i = 0; i < NRET; i++) n = n + NPUSH_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/mure_uop_fifo_if.sv
// mure_uop_fifo_if: commit-side write lanes and encoder-side valid/ready
// read port of the uop FIFO, plus its status flags.
//   slave  : the FIFO (consumes clear/valid_i/entry_i/ready_i)
//   master : upstream + encoder side
interface mure_uop_fifo_if
    import mure_pkg::*;
#(
    parameter int unsigned DEPTH = UOP_FIFO_DEPTH,
    parameter int unsigned NRET  = mure_pkg::NRET
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                         clear_i;
    logic        [NRET-1:0]       valid_i;
    fifo_entry_s [NRET-1:0]       entry_i;
    logic                         valid_o;
    fifo_entry_s                  entry_o;
    logic                         ready_i;
    logic        [CNT_W-1:0]      count_o;
    logic                         full_o;
    logic                         empty_o;
    logic                         ready_o;
    logic                         overflow_o;

    modport slave (
        input  clear_i, valid_i, entry_i, ready_i,
        output valid_o, entry_o, count_o, full_o, empty_o, ready_o, overflow_o
    );

    modport master (
        output clear_i, valid_i, entry_i, ready_i,
        input  valid_o, entry_o, count_o, full_o, empty_o, ready_o, overflow_o
    );

endinterface

// File: rtl/mure_uop_fifo.sv
// mure_uop_fifo: compacting multi-lane-write, single-read FWFT uop buffer
// between the commit interface and the trace encoder.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : clear_i, valid_i/entry_i (NRET lanes, lane 0 oldest),
//                   valid_o/entry_o/ready_i head port, count/full/empty,
//                   ready_o (room for NRET), sticky overflow_o
// The commit side cannot stall, so a cycle that does not fit is dropped
// whole and flagged rather than partially written.
module mure_uop_fifo
    import mure_pkg::*;
#(
    parameter int unsigned DEPTH = UOP_FIFO_DEPTH,
    // Must equal mure_pkg::NRET: the lane popcount helper is sized by it.
    parameter int unsigned NRET  = mure_pkg::NRET
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mure_uop_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fifo_entry_s      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic [CNT_W-1:0] n_push;
    logic             pop;
    logic [CNT_W:0]   free_eff;
    logic             accept;
    logic [PTR_W-1:0] lane_slot [NRET];

    assign n_push = CNT_W'(popcount_nret(bus.valid_i));
    assign pop    = bus.valid_o & bus.ready_i;

    // A pop in the same cycle frees its slot for this cycle's push.
    assign free_eff = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(pop);
    assign accept   = ({1'b0, n_push} <= free_eff);

    // Compaction: each valid lane lands at wr_ptr + (number of valid older
    // lanes); pointer arithmetic wraps modulo DEPTH by truncation.
    always_comb begin
        logic [PTR_W-1:0] off;
        off = '0;
        for (int l = 0; l < NRET; l++) begin
            lane_slot[l] = wr_ptr + off;
            off          = off + PTR_W'(bus.valid_i[l]);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && !bus.clear_i) begin
            for (int l = 0; l < NRET; l++) begin
                if (bus.valid_i[l]) mem[lane_slot[l]] <= bus.entry_i[l];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (bus.clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (accept ? n_push : '0) - CNT_W'(pop);
            if (!accept) overflow <= 1'b1;
        end
    end

    // First-word-fall-through head; zero when empty so idle output is clean.
    always_comb begin
        bus.entry_o = '0;
        if (bus.valid_o) begin
            bus.entry_o       = mem[rd_ptr];
            bus.entry_o.valid = 1'b1;
        end
    end

    // Status comes from the registered count only (no path from ready_i).
    assign bus.valid_o    = (count != '0);
    assign bus.empty_o    = (count == '0);
    assign bus.full_o     = (count == CNT_W'(DEPTH));
    assign bus.ready_o    = ((CNT_W'(DEPTH) - count) >= CNT_W'(NRET));
    assign bus.count_o    = count;
    assign bus.overflow_o = overflow;

endmodule
